mult16_seq: RTL and testbench
=============================

# mult16_seq

Sequential 16x16 multiplier built around a single 8x8 combinational `multiplier8` instance. It splits each operand into bytes and feeds the four byte pairs through the shared 8x8 core, one pair per cycle, accumulating the shifted 16-bit partial products into a 32-bit result. It sits directly upstream of `multiplier8`, driving its operands, and consumes its products. It is the 16-bit multiply stage exposed to the rest of the datapath through a start/done handshake.

## Interface
- No parameters. Widths are fixed at 16-bit operands and a 32-bit result, defined in the package.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `rst_n  in  1` — asynchronous, active-low reset.
- `start  in  1` — request; sampled only while `busy`=0.
- `a  in  16` — multiplicand; sampled on an accepted start.
- `b  in  16` — multiplier; sampled on an accepted start.
- `busy  out  1` — high while a multiply is in progress.
- `done  out  1` — one-cycle pulse; `result` is valid from this cycle.
- `result  out  32` — product; holds its value until the next completion.

## Operation
- FSM states: IDLE, MUL, DONE.
  - IDLE → MUL on `start`.
  - MUL → DONE after step 3.
  - DONE → IDLE unconditionally, or → MUL if `start`=1.
- Start acceptance: `start` is accepted only in IDLE or DONE, where `busy`=0.
- On an accepted start:
  - latch `a` and `b` into operand registers;
  - clear the 32-bit accumulator;
  - set step counter (2 bits) to 0.
- MUL, one step per cycle. The step selects the 8x8 core inputs and the left shift applied to its product:
  - step 0: a[7:0]·b[7:0], shift 0
  - step 1: a[7:0]·b[15:8], shift 8
  - step 2: a[15:8]·b[7:0], shift 8
  - step 3: a[15:8]·b[15:8], shift 16
- Each step: acc ← acc + (zero-extended 16-bit product << shift), in 32 bits. No overflow is possible for unsigned operands.
- Completion: at the step-3 edge, `result` ← final sum and the FSM enters DONE. Intermediate partial sums are never visible on `result`.
- `start` asserted while `busy`=1 is ignored entirely: no latch, no queueing.
- Operands changing after acceptance have no effect on the in-flight multiply.

## Timing
- Reset values: state=IDLE, step=0, `busy`=0, `done`=0, `result`=0, operand registers 0, accumulator 0.
- Start sampled at edge k:
  - `busy`=1 from edge k up to edge k+4.
  - Steps 0..3 complete at edges k+1..k+4.
  - `done`=1 and `result` valid for the cycle following edge k+4.
  - Latency is 4 cycles from start to `done`.
- Back-to-back: `start` held during the DONE cycle is accepted, giving a throughput of one result per 5 cycles.
- `rst_n` low mid-operation: all outputs and state return to reset values immediately. The in-flight result is discarded and `result` reads 0.

## Configuration
- `MULT16_SIGNED_EN` defined:
  - Operands are two's complement.
  - Magnitudes are taken at start; 0x8000 gives magnitude 0x8000, which fits unsigned.
  - The unsigned sequence above runs on the magnitudes.
  - On completion, `result` is negated if a[15]^b[15], with the sign latched at start.
  - Latency is unchanged.
- `MULT16_SIGNED_EN` undefined: operands are unsigned, with no sign logic.

## Structure
- Package `mult16_pkg` contains:
  - state enum (IDLE/MUL/DONE);
  - `OP_W`=16 and `RES_W`=32;
  - step width;
  - shift constants per step (0, 8, 8, 16).
- One sub-module: the existing `multiplier8` (8-bit a, 8-bit b, 16-bit result), instantiated once with a combinational operand mux in front. No other hierarchy.

## Test plan
- Reset, then a=3, b=5, start pulse → `busy` for 4 cycles; `done` pulse; `result`=0x0000000F.
- a=0xFFFF, b=0xFFFF → `result`=0xFFFE0001 (unsigned build); a=0x1234, b=0x5678 → 0x06260060.
- Signed check, a=0xFFFE, b=0x0003:
  - with `MULT16_SIGNED_EN`: `result`=0xFFFFFFFA;
  - without: 0x0002FFFA;
  - signed a=0x8000, b=0x8000 → 0x40000000.
- Start pulsed again at cycle 2 of a busy multiply with different operands → ignored; first result is correct, and exactly one `done` pulse.
- `start` held high continuously with a=2, b=7 → `done` every 5 cycles, each with `result`=0x0000000E.
- `rst_n` low for 1 cycle during step 2 → `busy`, `done` and `result` all 0; no `done` pulse follows; a new start then completes normally.

Source files
------------

// File: rtl/mult16_pkg.sv
// Shared widths, FSM states and per-step shift amounts for mult16_seq.
// Signed operation is enabled by defining MULT16_SIGNED_EN.
package mult16_pkg;

   localparam int OP_W   = 16;
   localparam int RES_W  = 32;
   localparam int STEP_W = 2;

   localparam logic [4:0] SHIFT_S0 = 5'd0;
   localparam logic [4:0] SHIFT_S1 = 5'd8;
   localparam logic [4:0] SHIFT_S2 = 5'd8;
   localparam logic [4:0] SHIFT_S3 = 5'd16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_e;

   function automatic logic [4:0] step_shift(
      input logic [STEP_W-1:0] s
   );
      logic [4:0] sh;
      sh = SHIFT_S0;
      unique case (s)
         2'd0: sh = SHIFT_S0;
         2'd1: sh = SHIFT_S1;
         2'd2: sh = SHIFT_S2;
         2'd3: sh = SHIFT_S3;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mult16_seq_if.sv
// Start/done handshake and operand/result bus of the 16-bit multiplier.
// Signed operation is enabled by defining MULT16_SIGNED_EN.
interface mult16_seq_if;
   import mult16_pkg::*;

   logic             start;
   logic [OP_W-1:0]  a;
   logic [OP_W-1:0]  b;
   logic             busy;
   logic             done;
   logic [RES_W-1:0] result;

   modport master (
      output start, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, a, b,
      output busy, done, result
   );

endinterface

// File: rtl/multiplier8.sv
// Combinational 8x8 unsigned multiplier core shared by mult16_seq.
// Signed operation of the parent is enabled by defining MULT16_SIGNED_EN.
module multiplier8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] result
);

   assign result = 16'(a) * 16'(b);

endmodule

// File: rtl/mult16_seq.sv
// 16x16 multiplier: four byte-pair steps through one shared 8x8 core.
// Define MULT16_SIGNED_EN for two's-complement operands.
module mult16_seq
   import mult16_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   mult16_seq_if.slave  bus
);

   state_e             state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [OP_W-1:0]    a_q, a_d;
   logic [OP_W-1:0]    b_q, b_d;
   logic [RES_W-1:0]   acc_q, acc_d;
   logic [RES_W-1:0]   res_q, res_d;

   logic [7:0]         m_a, m_b;
   logic [15:0]        prod;
   logic [RES_W-1:0]   pp;
   logic [RES_W-1:0]   sum;
   logic [RES_W-1:0]   fin;
   logic [OP_W-1:0]    a_in, b_in;

`ifdef MULT16_SIGNED_EN
   logic neg_q, neg_d;

   // Magnitudes feed the unsigned datapath; 0x8000 maps to itself.
   assign a_in = bus.a[OP_W-1] ? OP_W'(-bus.a) : bus.a;
   assign b_in = bus.b[OP_W-1] ? OP_W'(-bus.b) : bus.b;
   assign fin  = neg_q ? RES_W'(-sum) : sum;
`else
   assign a_in = bus.a;
   assign b_in = bus.b;
   assign fin  = sum;
`endif

   always_comb begin
      m_a = a_q[7:0];
      m_b = b_q[7:0];
      unique case (step_q)
         2'd0: begin m_a = a_q[7:0];  m_b = b_q[7:0];  end
         2'd1: begin m_a = a_q[7:0];  m_b = b_q[15:8]; end
         2'd2: begin m_a = a_q[15:8]; m_b = b_q[7:0];  end
         2'd3: begin m_a = a_q[15:8]; m_b = b_q[15:8]; end
      endcase
   end

   multiplier8 u_mul8 (
      .a      (m_a),
      .b      (m_b),
      .result (prod)
   );

   assign pp  = RES_W'(prod) << step_shift(step_q);
   assign sum = acc_q + pp;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
`ifdef MULT16_SIGNED_EN
      neg_d   = neg_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               state_d = S_MUL;
               step_d  = '0;
               a_d     = a_in;
               b_d     = b_in;
               acc_d   = '0;
`ifdef MULT16_SIGNED_EN
               neg_d   = bus.a[OP_W-1] ^ bus.b[OP_W-1];
`endif
            end
         end
         S_MUL: begin
            acc_d  = sum;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               res_d   = fin;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
`ifdef MULT16_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
`ifdef MULT16_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   assign bus.busy   = (state_q == S_MUL);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = res_q;

endmodule

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq: arithmetic/countdown model plus
// directed vectors with hand-computed products.
module tb_mult16_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mult16_seq_if bus();

   mult16_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
   endtask

   function automatic logic [31:0] product(input logic [15:0] x,
                                           input logic [15:0] y);
`ifdef MULT16_SIGNED_EN
      int sx, sy;
      sx = int'($signed(x));
      sy = int'($signed(y));
      return 32'(sx * sy);
`else
      longint ux, uy;
      ux = longint'(x);
      uy = longint'(y);
      return 32'(ux * uy);
`endif
   endfunction

   // Model: a busy countdown and the pending product of the accepted pair.
   int          m_cnt  = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_res  = '0;
   bit          m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  = 0;
         m_pend = '0;
         m_res  = '0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_res  = m_pend;
               m_done = 1'b1;
            end
         end else if (bus.start) begin
            m_cnt  = 4;
            m_pend = product(bus.a, bus.b);
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(m_cnt > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("result", bus.result, m_res);
   end

   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [31:0] exp, input string nm);
      int busy_n;
      bit got;
      busy_n = 0;
      got    = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ia;
      bus.b     = ib;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 16'hA5A5;
      bus.b     = 16'h5A5A;
      for (int i = 0; i < 12 && !got; i++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin
            got = 1'b1;
            chk(nm, bus.result, exp);
            chk({"model_", nm}, m_res, exp);
         end else begin
            @(negedge clk);
         end
      end
      chk({nm, "_done_seen"}, 32'(got), 32'd1);
      chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd4);
   endtask

   initial begin
      int dones;
      int last;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      #2 rst_n = 1'b1;

      run_op(16'd3, 16'd5, 32'h0000_000F, "3x5");
`ifdef MULT16_SIGNED_EN
      run_op(16'hFFFF, 16'hFFFF, 32'h0000_0001, "ffffxffff");
      run_op(16'hFFFE, 16'h0003, 32'hFFFF_FFFA, "m2x3");
`else
      run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "ffffxffff");
      run_op(16'hFFFE, 16'h0003, 32'h0002_FFFA, "m2x3");
`endif
      run_op(16'h1234, 16'h5678, 32'h0626_0060, "1234x5678");
      run_op(16'h8000, 16'h8000, 32'h4000_0000, "8000x8000");
      run_op(16'h0000, 16'h1234, 32'h0000_0000, "zero");

      // Start re-pulsed mid-flight must be dropped.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd9;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd100;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done) begin
            dones++;
            chk("ignored_start_result", bus.result, 32'd18);
         end
         @(negedge clk);
      end
      chk("ignored_start_dones", 32'(dones), 32'd1);

      // Continuous start: one result every 5 cycles.
      bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd7;
      dones = 0;
      last  = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done) begin
            chk("held_result", bus.result, 32'h0000_000E);
            if (last >= 0) chk("held_period", 32'(i - last), 32'd5);
            last = i;
            dones++;
         end
      end
      chk("held_dones", 32'(dones), 32'd4);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);

      // Reset during step 2 discards the in-flight result.
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_result", bus.result, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("midrst_no_done", 32'(dones), 32'd0);
      chk("midrst_result_held", bus.result, 32'd0);
      run_op(16'd3, 16'd5, 32'h0000_000F, "after_rst");

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1);
   end

endmodule
